// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU operation responder.
package alu_pkg;

   localparam int OPCODE_W = 4;

   typedef enum logic [OPCODE_W-1:0] {
      OP_AND = 4'd0,
      OP_OR  = 4'd1,
      OP_XOR = 4'd2,
      OP_NOT = 4'd3,
      OP_ADD = 4'd4,
      OP_SUB = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7
   } alu_op_e;

endpackage

// File: rtl/alu_result_fifo.sv
// In-order synchronous FIFO holding computed results; exposes occupancy count.
module alu_result_fifo #(
   parameter  int DEPTH = 4,
   parameter  int DW    = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/alu_op_responder.sv
// Flow-controlled 8-op ALU: request handshake -> registered compute -> result FIFO.
// Build option ALU_ILLEGAL_OP_EN flags opcodes 8-15 as errors instead of aliasing them.
module alu_op_responder
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   input  logic [OPCODE_W-1:0] in_op,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_f,
   output logic                out_carry,
   output logic                out_zero,
   output logic [TAG_W-1:0]    out_tag,
   output logic                out_err,
   output logic [15:0]         done_count
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [WIDTH-1:0] f;
      logic             carry;
      logic             zero;
      logic [TAG_W-1:0] tag;
      logic             err;
   } alu_res_t;

   localparam int RES_W = $bits(alu_res_t);

`ifdef ALU_ILLEGAL_OP_EN
   localparam bit ILLEGAL_EN = 1'b1;
`else
   localparam bit ILLEGAL_EN = 1'b0;
`endif

   logic                s1_valid;
   logic [WIDTH-1:0]    s1_a, s1_b;
   logic [OPCODE_W-1:0] s1_op;
   logic [TAG_W-1:0]    s1_tag;
   logic [TAG_W-1:0]    tag_cnt;
   logic [OPCODE_W-1:0] op_cap;
   logic                accept, pop;
   logic [CW-1:0]       fifo_count;
   logic [CW:0]         occ;
   logic [RES_W-1:0]    fifo_dout;
   alu_res_t            res, head;

`ifdef ALU_ILLEGAL_OP_EN
   assign op_cap = in_op;
`else
   logic unused_op_msb;
   assign unused_op_msb = in_op[OPCODE_W-1];
   assign op_cap        = {1'b0, in_op[OPCODE_W-2:0]};
`endif

   // Credit counts the result already in flight in S1, so a push can never hit a full FIFO.
   assign occ      = {1'b0, fifo_count} + (CW+1)'(s1_valid);
   assign in_ready = occ < (CW+1)'(DEPTH);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
         tag_cnt  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_op   <= op_cap;
            s1_tag  <= tag_cnt;
            tag_cnt <= tag_cnt + TAG_W'(1);
         end
      end
   end

   always_comb begin
      res     = '0;
      res.tag = s1_tag;
      case (alu_op_e'(s1_op))
         OP_AND: res.f = s1_a & s1_b;
         OP_OR:  res.f = s1_a | s1_b;
         OP_XOR: res.f = s1_a ^ s1_b;
         OP_NOT: res.f = ~s1_a;
         OP_ADD: {res.carry, res.f} = {1'b0, s1_a} + {1'b0, s1_b};
         OP_SUB: {res.carry, res.f} = {1'b0, s1_a} - {1'b0, s1_b};
         OP_SHL: begin
            res.f     = {s1_a[WIDTH-2:0], 1'b0};
            res.carry = s1_a[WIDTH-1];
         end
         OP_SHR: begin
            res.f     = {1'b0, s1_a[WIDTH-1:1]};
            res.carry = s1_a[0];
         end
         default: res.err = ILLEGAL_EN;
      endcase
      res.zero = (res.f == '0);
   end

   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid & out_ready;

   alu_result_fifo #(
      .DEPTH (DEPTH),
      .DW    (RES_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s1_valid),
      .din   (res),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign head      = alu_res_t'(fifo_dout);
   assign out_f     = out_valid ? head.f     : '0;
   assign out_carry = out_valid ? head.carry : 1'b0;
   assign out_zero  = out_valid ? head.zero  : 1'b0;
   assign out_tag   = out_valid ? head.tag   : '0;
   assign out_err   = out_valid ? head.err   : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      done_count <= '0;
      else if (pop) done_count <= done_count + 16'd1;
   end

endmodule

// File: tb/tb_alu_op_responder.sv
// Scoreboard bench for alu_op_responder: random and directed requests vs a behavioural model.
module tb_alu_op_responder;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid, in_ready;
   logic [WIDTH-1:0] in_a, in_b;
   logic [3:0]       in_op;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] out_f;
   logic             out_carry, out_zero, out_err;
   logic [TAG_W-1:0] out_tag;
   logic [15:0]      done_count;

   alu_op_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_f      (out_f),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_tag    (out_tag),
      .out_err    (out_err),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int f;
      int carry;
      int zero;
      int tag;
      int err;
   } exp_t;

   exp_t q[$];
   int   n_checks    = 0;
   int   n_err       = 0;
   int   outstanding = 0;
   int   model_tag   = 0;
   int   exp_done    = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result computed from the opcode table with plain integer arithmetic.
   function automatic exp_t ref_model(input int a, input int b, input int op, input int tag);
      exp_t e;
      int   r = 0, c = 0, er = 0, o = op;
`ifndef ALU_ILLEGAL_OP_EN
      o = op % 8;
`endif
      case (o)
         0: r = a & b;
         1: r = a | b;
         2: r = a ^ b;
         3: r = 255 - a;
         4: begin r = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
         5: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
         6: begin r = (a * 2) % 256; c = a / 128; end
         7: begin r = a / 2; c = a % 2; end
         default: er = 1;
      endcase
      e.f = r; e.carry = c; e.zero = (r == 0) ? 1 : 0; e.tag = tag; e.err = er;
      return e;
   endfunction

   // Monitor: tracks accepts/pops away from the rising edge and scores each popped result.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         outstanding = 0;
         model_tag   = 0;
         exp_done    = 0;
      end else begin
         exp_t e;
         chk("done_count", int'(done_count), exp_done);
         chk("in_ready", int'(in_ready), (outstanding < DEPTH) ? 1 : 0);
         if (in_valid && in_ready) begin
            q.push_back(ref_model(int'(in_a), int'(in_b), int'(in_op), model_tag));
            model_tag = (model_tag + 1) % (1 << TAG_W);
            outstanding++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_pop: got out_valid=1 expected empty queue at %0t", $time);
            end else begin
               e = q.pop_front();
               chk("out_f", int'(out_f), e.f);
               chk("out_carry", int'(out_carry), e.carry);
               chk("out_zero", int'(out_zero), e.zero);
               chk("out_tag", int'(out_tag), e.tag);
               chk("out_err", int'(out_err), e.err);
            end
            outstanding--;
            exp_done = (exp_done + 1) % 65536;
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      bit ok;
      int n = 0;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         n++;
      end while (!ok && n < 100);
      #1 in_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q.size() != 0 || outstanding != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 300) chk("drain_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_f", int'(out_f), 0);
      chk("rst_out_carry", int'(out_carry), 0);
      chk("rst_out_zero", int'(out_zero), 0);
      chk("rst_out_tag", int'(out_tag), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_done_count", int'(done_count), 0);
      rst = 1'b0;

      // Single OR: out_valid low just after accept, high one edge later.
      out_ready = 1'b1;
      send(8'h01, 8'h01, 4'd1);
      chk("lat_after_accept", int'(out_valid), 0);
      @(posedge clk);
      #1 chk("lat_after_push", int'(out_valid), 1);
      wait_drain();

      // Back-to-back stream.
      send(8'hFF, 8'h7B, 4'd1);
      send(8'h87, 8'h0A, 4'd1);
      send(8'hFF, 8'h01, 4'd4);
      wait_drain();

      // Backpressure fills exactly DEPTH credits.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      repeat (8) begin
         in_a  = 8'($urandom);
         in_b  = 8'($urandom);
         in_op = 4'($urandom_range(0, 7));
         @(posedge clk);
         #1;
      end
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_accepted", q.size(), DEPTH);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      send(8'h00, 8'h01, 4'd5);
      send(8'h81, 8'h00, 4'd7);
      send(8'h81, 8'h00, 4'd6);
      wait_drain();

      // Tag wrap after a fresh reset.
      do_reset();
      for (int i = 0; i < 17; i++)
         send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)));
      wait_drain();
      chk("done_after_17", int'(done_count), 17);

      // Random traffic with random backpressure.
      repeat (300) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         in_op     = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Reset with results buffered discards them immediately.
      out_ready = 1'b0;
      send(8'h11, 8'h22, 4'd4);
      send(8'h33, 8'h44, 4'd2);
      send(8'h55, 8'h66, 4'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_done_count", int'(done_count), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      send(8'h3C, 8'h0F, 4'd9);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
